// File: rtl/rst_seq_pkg.sv
`default_nettype none
// rst_seq_pkg: shared types, default parameters and width helper for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    localparam int DEF_NUM_STAGES  = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 8;
    localparam int DEF_STAGE_GAP   = 4;

    // One counter serves both the hold period and the inter-stage gap.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_sync_n.sv
`default_nettype none
// rst_sync_n: async-assert / sync-deassert reset synchroniser, active-low in and out.
module rst_sync_n #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic rst_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_s = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_sequencer.sv
`default_nettype none
// rst_sequencer: asserts a bank of active-low resets asynchronously and releases them
// in order after a synchronised deassertion, with a hold period and per-stage gaps.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGE_GAP   = DEF_STAGE_GAP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  seq_busy,
    output logic                  seq_done
);

    localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam int IW = $clog2(NUM_STAGES) + 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);

    logic rst_s;

    rst_sync_n #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .rst_s (rst_s)
    );

    seq_state_t            state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [IW-1:0]         idx, idx_nx;
    logic [NUM_STAGES-1:0] out_nx;
    logic                  busy_nx, done_nx;
    logic                  sw_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HOLD;
            cnt      <= '0;
            idx      <= '0;
            rst_out  <= '0;
            seq_busy <= 1'b1;
            seq_done <= 1'b0;
            sw_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            idx      <= idx_nx;
            rst_out  <= out_nx;
            seq_busy <= busy_nx;
            seq_done <= done_nx;
            sw_q     <= sw_rst_req;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        out_nx   = rst_out;
        busy_nx  = seq_busy;
        done_nx  = 1'b0;

        if (sw_rst_req) begin
            state_nx = HOLD;
            cnt_nx   = '0;
            idx_nx   = '0;
            out_nx   = '0;
            busy_nx  = 1'b1;
        end else if (rst_s) begin
            case (state)
                // The edge on which a request drops is the reference point, so
                // counting starts only once the previous sample was also low.
                HOLD: begin
                    if (!sw_q) begin
                        if (cnt == HOLD_LAST) begin
                            cnt_nx    = '0;
                            out_nx[0] = 1'b1;
                            if (NUM_STAGES == 1) begin
                                state_nx = RUN;
                                busy_nx  = 1'b0;
                                done_nx  = 1'b1;
                            end else begin
                                state_nx = RELEASE;
                                idx_nx   = IW'(1);
                            end
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt_nx = '0;
                        idx_nx = idx + 1'b1;
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (IW'(k) == idx) begin
                                out_nx[k] = 1'b1;
                            end
                        end
                        if (idx == LAST_IDX) begin
                            state_nx = RUN;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                RUN: begin
                end
                default: begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                    out_nx   = '0;
                    busy_nx  = 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// tb_rst_sequencer: scoreboard bench; expected output-change events are queued by the
// stimulus and popped by per-instance monitors whenever a DUT output changes.
module tb_rst_sequencer;

    typedef struct packed {
        int         cyc;
        logic [7:0] out;
        logic       busy;
        logic       done;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       sw;
    logic       sw_off;
    logic [3:0] out4;
    logic       busy4, done4;
    logic [0:0] out1;
    logic       busy1, done1;
    logic [7:0] out8;
    logic       busy8, done8;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t q4[$];
    ev_t q1[$];
    ev_t q8[$];
    logic [9:0] prev4 = 10'b0000000010;
    logic [9:0] prev1 = 10'b0000000010;
    logic [9:0] prev8 = 10'b0000000010;

    rst_sequencer dut4 (
        .clk(clk), .rst(rst), .sw_rst_req(sw),
        .rst_out(out4), .seq_busy(busy4), .seq_done(done4)
    );

    rst_sequencer #(
        .NUM_STAGES(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .STAGE_GAP(1)
    ) dut1 (
        .clk(clk), .rst(rst), .sw_rst_req(sw_off),
        .rst_out(out1), .seq_busy(busy1), .seq_done(done1)
    );

    rst_sequencer #(
        .NUM_STAGES(8), .SYNC_STAGES(2), .HOLD_CYCLES(2), .STAGE_GAP(3)
    ) dut8 (
        .clk(clk), .rst(rst), .sw_rst_req(sw_off),
        .rst_out(out8), .seq_busy(busy8), .seq_done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input logic [7:0] o, input logic b, input logic d);
        ev_t e;
        e.cyc  = c;
        e.out  = o;
        e.busy = b;
        e.done = d;
        return e;
    endfunction

    task automatic cmp(input string nm, input ev_t a, input ev_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got cyc=%0d out=%h busy=%b done=%b, want cyc=%0d out=%h busy=%b done=%b",
                     nm, a.cyc, a.out, a.busy, a.done, e.cyc, e.out, e.busy, e.done);
        end
    endtask

    task automatic unexpected(input string nm, input ev_t a);
        checks++;
        errors++;
        $display("FAIL %s_unexpected: got cyc=%0d out=%h busy=%b done=%b, want no change",
                 nm, a.cyc, a.out, a.busy, a.done);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Action point: 3 time units after rising edge n.
    task automatic at_cyc(input int n);
        #(10 * n - 2 - $time);
    endtask

    // Default instance: stage 0 at e0, then every 4 edges; done pulse on the last.
    task automatic push4(input int e0);
        q4.push_back(mk(e0,      8'h01, 1'b1, 1'b0));
        q4.push_back(mk(e0 + 4,  8'h03, 1'b1, 1'b0));
        q4.push_back(mk(e0 + 8,  8'h07, 1'b1, 1'b0));
        q4.push_back(mk(e0 + 12, 8'h0F, 1'b0, 1'b1));
        q4.push_back(mk(e0 + 13, 8'h0F, 1'b0, 1'b0));
    endtask

    task automatic push8(input int e0);
        for (int k = 0; k < 8; k++) begin
            q8.push_back(mk(e0 + 3 * k, 8'((1 << (k + 1)) - 1), (k < 7), (k == 7)));
        end
        q8.push_back(mk(e0 + 22, 8'hFF, 1'b0, 1'b0));
    endtask

    always @(negedge clk) begin
        if ({8'(out4), busy4, done4} !== prev4) begin
            prev4 = {8'(out4), busy4, done4};
            if (q4.size() == 0) unexpected("n4", mk(cyc, 8'(out4), busy4, done4));
            else cmp("n4_event", mk(cyc, 8'(out4), busy4, done4), q4.pop_front());
        end
        if ({8'(out1), busy1, done1} !== prev1) begin
            prev1 = {8'(out1), busy1, done1};
            if (q1.size() == 0) unexpected("n1", mk(cyc, 8'(out1), busy1, done1));
            else cmp("n1_event", mk(cyc, 8'(out1), busy1, done1), q1.pop_front());
        end
        if ({out8, busy8, done8} !== prev8) begin
            prev8 = {out8, busy8, done8};
            if (q8.size() == 0) unexpected("n8", mk(cyc, out8, busy8, done8));
            else cmp("n8_event", mk(cyc, out8, busy8, done8), q8.pop_front());
        end
    end

    initial begin
        rst    = 1'b0;
        sw     = 1'b0;
        sw_off = 1'b0;

        // Power-on: release at 23, rst_s at edge 4 (35).
        push4(12);
        q1.push_back(mk(5, 8'h01, 1'b0, 1'b1));
        q1.push_back(mk(6, 8'h01, 1'b0, 1'b0));
        push8(6);
        #10;
        chk("reset_out4",  8'(out4), 8'h00);
        chk("reset_busy4", 8'(busy4), 8'h01);
        chk("reset_done4", 8'(done4), 8'h00);
        chk("reset_out1",  8'(out1), 8'h00);
        chk("reset_out8",  out8, 8'h00);
        #13 rst = 1'b1;

        // Board reset while every instance is running, then again mid-gap.
        at_cyc(30);
        q4.push_back(mk(30, 8'h00, 1'b1, 1'b0));
        q1.push_back(mk(30, 8'h00, 1'b1, 1'b0));
        q8.push_back(mk(30, 8'h00, 1'b1, 1'b0));
        rst = 1'b0;
        #1;
        chk("async_out4",  8'(out4), 8'h00);
        chk("async_busy4", 8'(busy4), 8'h01);
        chk("async_out8",  out8, 8'h00);
        q4.push_back(mk(41, 8'h01, 1'b1, 1'b0));
        q4.push_back(mk(45, 8'h03, 1'b1, 1'b0));
        q4.push_back(mk(46, 8'h00, 1'b1, 1'b0));
        q1.push_back(mk(34, 8'h01, 1'b0, 1'b1));
        q1.push_back(mk(35, 8'h01, 1'b0, 1'b0));
        q1.push_back(mk(46, 8'h00, 1'b1, 1'b0));
        q8.push_back(mk(35, 8'h01, 1'b1, 1'b0));
        q8.push_back(mk(38, 8'h03, 1'b1, 1'b0));
        q8.push_back(mk(41, 8'h07, 1'b1, 1'b0));
        q8.push_back(mk(44, 8'h0F, 1'b1, 1'b0));
        q8.push_back(mk(46, 8'h00, 1'b1, 1'b0));
        at_cyc(31);
        rst = 1'b1;
        at_cyc(46);
        rst = 1'b0;
        #1;
        chk("midseq_out4", 8'(out4), 8'h00);
        push4(57);
        q1.push_back(mk(50, 8'h01, 1'b0, 1'b1));
        q1.push_back(mk(51, 8'h01, 1'b0, 1'b0));
        push8(51);
        at_cyc(47);
        rst = 1'b1;

        // One-cycle software request sampled at edge 76.
        at_cyc(75);
        q4.push_back(mk(76, 8'h00, 1'b1, 1'b0));
        push4(85);
        sw = 1'b1;
        at_cyc(76);
        sw = 1'b0;

        // Request held for edges 101..120; first low edge is 121.
        at_cyc(100);
        q4.push_back(mk(101, 8'h00, 1'b1, 1'b0));
        push4(129);
        sw = 1'b1;
        at_cyc(110);
        chk("held_out4",  8'(out4), 8'h00);
        chk("held_busy4", 8'(busy4), 8'h01);
        at_cyc(120);
        sw = 1'b0;

        // Collision: request lands on the edge that would release stage 3.
        at_cyc(145);
        q4.push_back(mk(146, 8'h00, 1'b1, 1'b0));
        q4.push_back(mk(155, 8'h01, 1'b1, 1'b0));
        q4.push_back(mk(159, 8'h03, 1'b1, 1'b0));
        q4.push_back(mk(163, 8'h07, 1'b1, 1'b0));
        q4.push_back(mk(167, 8'h00, 1'b1, 1'b0));
        push4(176);
        sw = 1'b1;
        at_cyc(146);
        sw = 1'b0;
        at_cyc(166);
        sw = 1'b1;
        at_cyc(167);
        sw = 1'b0;

        at_cyc(195);
        chk("q4_drained", 8'(q4.size()), 8'h00);
        chk("q1_drained", 8'(q1.size()), 8'h00);
        chk("q8_drained", 8'(q8.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
